rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_pkg.sv | 30 +++
 rtl/rr_arb2.sv | 58 +++++
 rtl/rf_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg -- shared definitions for the register-file writeback arbiter slice.
//
// Contents:
//   DW, AW, NREG   default data width, address width and register count
//   rf_addr_t      register address
//   rf_data_t      register data
//   wb_req_t       one writeback request {addr, data}
//   prio_e         which requester wins the next tie in the 2-way arbiter
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int DW   = 16;
    localparam int AW   = 5;
    localparam int NREG = 2 ** AW;

    typedef logic [AW-1:0] rf_addr_t;
    typedef logic [DW-1:0] rf_data_t;

    typedef struct packed {
        rf_addr_t addr;
        rf_data_t data;
    } wb_req_t;

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_LSU = 1'b1
    } prio_e;

endpackage : rf_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2 -- two-way round-robin arbiter.
//
// A lone requester is granted immediately. On a tie the requester that was
// not granted most recently wins. The priority pointer moves only when a
// grant is issued; the caller guarantees a grant is always an accepted
// transfer (grant implies request, and the grant is the ready).
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-high; pointer returns to ALU-first
//   i_req    in   [1:0] request, bit0 = ALU, bit1 = LSU
//   o_gnt    out  [1:0] one-hot or zero grant, combinational
// -----------------------------------------------------------------------------
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    prio_e r_prio;
    prio_e w_prio_next;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= PRIO_ALU;
        end else begin
            r_prio <= w_prio_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        o_gnt       = 2'b00;
        w_prio_next = r_prio;

        unique case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (r_prio == PRIO_ALU) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase

        // Whoever was just served drops to the back of the line.
        if (o_gnt[0]) begin
            w_prio_next = PRIO_LSU;
        end else if (o_gnt[1]) begin
            w_prio_next = PRIO_ALU;
        end
    end

endmodule : rr_arb2

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter -- merges ALU and LSU writebacks into the single register-file
// write port and, optionally, tracks destinations with outstanding writes.
//
// Writeback path: at most one request is accepted per cycle (round-robin on
// ties). The accepted request is registered and presented to the register
// file for exactly the following cycle. Writes to r0 are accepted and
// silently dropped.
//
// Scoreboard (macro RF_WB_SCOREBOARD_EN): one pending bit per register r1..rN.
// An accepted issue claim sets the bit; a register-file write clears it at the
// end of the write cycle; a coincident set and clear leaves it set. Without
// the macro there is no pending storage, issue_ready is 1 and q_busy is 0.
//
// Ports:
//   clk                 in   clock
//   reset               in   synchronous, active-high
//   wb_valid[1:0]       in   writeback request, bit0 = ALU, bit1 = LSU
//   wb_addr0/wb_addr1   in   destination register per requester
//   wb_data0/wb_data1   in   write data per requester
//   wb_ready[1:0]       out  accept (combinational, at most one bit set)
//   rf_write            out  register-file write enable
//   rf_w_addr           out  register-file write address
//   rf_d_in             out  register-file write data
//   issue_valid         in   decode claims a destination register
//   issue_addr          in   claimed destination
//   issue_ready         out  claim accepted (no WAW hazard)
//   q_addr              in   operand hazard query address
//   q_busy              out  queried register has a pending write
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int DW = rf_pkg::DW,
    parameter int AW = rf_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    wb_valid,
    input  logic [AW-1:0] wb_addr0,
    input  logic [AW-1:0] wb_addr1,
    input  logic [DW-1:0] wb_data0,
    input  logic [DW-1:0] wb_data1,
    output logic [1:0]    wb_ready,
    output logic          rf_write,
    output logic [AW-1:0] rf_w_addr,
    output logic [DW-1:0] rf_d_in,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_addr,
    output logic          issue_ready,
    input  logic [AW-1:0] q_addr,
    output logic          q_busy
);

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [1:0]    w_req;
    logic [1:0]    w_gnt;
    logic          w_xfer;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_data;

    // Nothing is accepted while reset is held, so queued requests survive it.
    assign w_req = wb_valid & {2{~reset}};

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign wb_ready   = w_gnt;
    assign w_xfer     = |w_gnt;
    assign w_sel_addr = w_gnt[1] ? wb_addr1 : wb_addr0;
    assign w_sel_data = w_gnt[1] ? wb_data1 : wb_data0;

    // -------------------------------------------------------------------------
    // Registered write stage
    // -------------------------------------------------------------------------
    logic          r_write;
    logic [AW-1:0] r_w_addr;
    logic [DW-1:0] r_d_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write  <= 1'b0;
            r_w_addr <= '0;
            r_d_in   <= '0;
        end else begin
            // r0 is architecturally zero: accept the transfer, suppress the write.
            r_write <= w_xfer && (w_sel_addr != '0);
            if (w_xfer) begin
                r_w_addr <= w_sel_addr;
                r_d_in   <= w_sel_data;
            end
        end
    end

    assign rf_write  = r_write;
    assign rf_w_addr = r_w_addr;
    assign rf_d_in   = r_d_in;

    // -------------------------------------------------------------------------
    // Pending-write scoreboard
    // -------------------------------------------------------------------------
`ifdef RF_WB_SCOREBOARD_EN
    localparam int NR = 2 ** AW;

    logic [NR-1:0] r_pending;
    logic [NR-1:0] w_pending_next;
    logic          w_issue_set;

    assign issue_ready = ~reset & ~r_pending[issue_addr];
    assign q_busy      = r_pending[q_addr];
    assign w_issue_set = issue_valid & issue_ready & (issue_addr != '0);

    always_comb begin
        w_pending_next = r_pending;
        if (r_write) begin
            w_pending_next[r_w_addr] = 1'b0;
        end
        // Applied after the clear so a same-cycle claim of the register being
        // written keeps it pending for the new producer.
        if (w_issue_set) begin
            w_pending_next[issue_addr] = 1'b1;
        end
        // r0 never carries a hazard; issue_ready and q_busy rely on this.
        w_pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end
`else
    logic w_unused;

    assign issue_ready = 1'b1;
    assign q_busy      = 1'b0;
    assign w_unused    = ^{issue_valid, issue_addr, q_addr};
`endif

endmodule : rf_wb_arbiter

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter -- self-checking bench for rf_wb_arbiter.
//
// Two requester queues feed the DUT; a reference model tracks fairness as
// "who was served last", the write stage as a one-cycle-late copy of the
// accepted request, and the scoreboard as a plain array of pending flags.
// Directed scenarios come first, then a randomized run.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;
    import rf_pkg::*;

`ifdef RF_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] wb_valid = 2'b00;
    rf_addr_t   wb_addr0 = '0, wb_addr1 = '0;
    rf_data_t   wb_data0 = '0, wb_data1 = '0;
    logic [1:0] wb_ready;
    logic       rf_write;
    rf_addr_t   rf_w_addr;
    rf_data_t   rf_d_in;
    logic       issue_valid = 1'b0;
    rf_addr_t   issue_addr = '0;
    logic       issue_ready;
    rf_addr_t   q_addr = '0;
    logic       q_busy;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_valid    (wb_valid),
        .wb_addr0    (wb_addr0),
        .wb_addr1    (wb_addr1),
        .wb_data0    (wb_data0),
        .wb_data1    (wb_data1),
        .wb_ready    (wb_ready),
        .rf_write    (rf_write),
        .rf_w_addr   (rf_w_addr),
        .rf_d_in     (rf_d_in),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .q_addr      (q_addr),
        .q_busy      (q_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- requester queues and reference model ----------------
    wb_req_t  q0[$];
    wb_req_t  q1[$];
    int       last_served = 1;      // 1 = LSU served last, so ALU wins the first tie
    bit       pend [NREG];
    bit       m_write = 1'b0;
    rf_addr_t m_addr  = '0;
    rf_data_t m_data  = '0;
    bit       m_known = 1'b1;       // addr/data content is defined by the model

    // Observations of the most recent step, for directed checks.
    logic [1:0] obs_ready;
    logic       obs_write, obs_ir, obs_qb;
    rf_addr_t   obs_addr;
    rf_data_t   obs_data;

    // One clock cycle: check registered outputs, drive, check combinational
    // outputs, then advance the model to the coming posedge.
    task automatic step(input bit rst, input bit iv, input rf_addr_t ia, input rf_addr_t qa);
        logic [1:0] eg;
        bit         eir, eqb;
        wb_req_t    sel;

        @(negedge clk);
        obs_write = rf_write;
        obs_addr  = rf_w_addr;
        obs_data  = rf_d_in;
        check("rf_write", {31'd0, rf_write}, {31'd0, m_write});
        if (m_known) begin
            check("rf_w_addr", {27'd0, rf_w_addr}, {27'd0, m_addr});
            check("rf_d_in", {16'd0, rf_d_in}, {16'd0, m_data});
        end

        reset       = rst;
        wb_valid    = {q1.size() > 0, q0.size() > 0};
        wb_addr0    = (q0.size() > 0) ? q0[0].addr : '0;
        wb_data0    = (q0.size() > 0) ? q0[0].data : '0;
        wb_addr1    = (q1.size() > 0) ? q1[0].addr : '0;
        wb_data1    = (q1.size() > 0) ? q1[0].data : '0;
        issue_valid = iv;
        issue_addr  = ia;
        q_addr      = qa;
        #1;

        if (rst)                    eg = 2'b00;
        else if (wb_valid == 2'b11) eg = (last_served == 0) ? 2'b10 : 2'b01;
        else                        eg = wb_valid;
        if (SB) begin
            eir = !rst && !pend[ia];
            eqb = pend[qa];
        end else begin
            eir = 1'b1;
            eqb = 1'b0;
        end

        obs_ready = wb_ready;
        obs_ir    = issue_ready;
        obs_qb    = q_busy;
        check("wb_ready", {30'd0, wb_ready}, {30'd0, eg});
        check("issue_ready", {31'd0, issue_ready}, {31'd0, eir});
        check("q_busy", {31'd0, q_busy}, {31'd0, eqb});

        if (rst) begin
            m_write = 1'b0;
            m_addr  = '0;
            m_data  = '0;
            m_known = 1'b1;
            foreach (pend[i]) pend[i] = 1'b0;
            last_served = 1;
        end else begin
            if (m_write) pend[m_addr] = 1'b0;
            if (iv && eir && ia != 0) pend[ia] = 1'b1;
            if (eg != 2'b00) begin
                if (eg[1]) sel = q1.pop_front();
                else       sel = q0.pop_front();
                last_served = eg[1] ? 1 : 0;
                m_write = (sel.addr != 0);
                m_addr  = sel.addr;
                m_data  = sel.data;
                m_known = (sel.addr != 0);
            end else begin
                m_write = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        wb_req_t r;

        // Reset state
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0);
        check("reset_rf_write", {31'd0, obs_write}, 32'd0);
        check("reset_rf_w_addr", {27'd0, obs_addr}, 32'd0);
        check("reset_rf_d_in", {16'd0, obs_data}, 32'd0);

        // Single ALU writeback
        r = '{addr: 5'd3, data: 16'hBEEF};
        q0.push_back(r);
        step(1'b0, 1'b0, '0, '0);
        check("alu_only_ready", {30'd0, obs_ready}, 32'd1);
        step(1'b0, 1'b0, '0, '0);
        check("alu_only_write", {31'd0, obs_write}, 32'd1);
        check("alu_only_addr", {27'd0, obs_addr}, 32'd3);
        check("alu_only_data", {16'd0, obs_data}, 32'hBEEF);

        // Continuous tie right after reset alternates, starting with ALU
        step(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            r = '{addr: rf_addr_t'(10 + i), data: rf_data_t'(16'hA000 + i)};
            q0.push_back(r);
            r = '{addr: rf_addr_t'(20 + i), data: rf_data_t'(16'hB000 + i)};
            q1.push_back(r);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, '0, '0);
            if (i < 4) check("tie_grant", {30'd0, obs_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) check("tie_write", {31'd0, obs_write}, 32'd1);
        end
        idle(3);

        // Claim r5, re-claim blocked, writeback releases it
        step(1'b0, 1'b1, 5'd5, 5'd5);
        check("claim5_ready", {31'd0, obs_ir}, 32'd1);
        step(1'b0, 1'b1, 5'd5, 5'd5);
        check("claim5_busy", {31'd0, obs_qb}, {31'd0, SB});
        check("claim5_waw", {31'd0, obs_ir}, {31'd0, !SB});
        r = '{addr: 5'd5, data: 16'h1234};
        q1.push_back(r);
        step(1'b0, 1'b0, '0, 5'd5);
        step(1'b0, 1'b0, '0, 5'd5);
        check("wb5_write", {31'd0, obs_write}, 32'd1);
        check("wb5_still_busy", {31'd0, obs_qb}, {31'd0, SB});
        step(1'b0, 1'b0, '0, 5'd5);
        check("wb5_released", {31'd0, obs_qb}, 32'd0);

        // Same-cycle claim and write of r7: claim wins
        r = '{addr: 5'd7, data: 16'hAAAA};
        q0.push_back(r);
        step(1'b0, 1'b0, '0, 5'd7);
        step(1'b0, 1'b1, 5'd7, 5'd7);
        check("r7_write", {31'd0, obs_write}, 32'd1);
        step(1'b0, 1'b0, '0, 5'd7);
        check("r7_pending", {31'd0, obs_qb}, {31'd0, SB});

        // LSU writeback to r0, claim of r0
        r = '{addr: 5'd0, data: 16'h5555};
        q1.push_back(r);
        step(1'b0, 1'b1, 5'd0, 5'd0);
        check("r0_ready", {30'd0, obs_ready}, 32'd2);
        check("r0_issue_ready", {31'd0, obs_ir}, 32'd1);
        check("r0_busy", {31'd0, obs_qb}, 32'd0);
        step(1'b0, 1'b0, '0, '0);
        check("r0_no_write", {31'd0, obs_write}, 32'd0);

        // Transfer, then reset: write discarded, pending cleared, ALU-first tie
        r = '{addr: 5'd9, data: 16'h0909};
        q0.push_back(r);
        step(1'b0, 1'b1, 5'd11, 5'd11);
        r = '{addr: 5'd12, data: 16'h0C0C};
        q0.push_back(r);
        r = '{addr: 5'd13, data: 16'h0D0D};
        q1.push_back(r);
        step(1'b1, 1'b0, '0, 5'd11);
        check("rst_no_accept", {30'd0, obs_ready}, 32'd0);
        step(1'b0, 1'b0, '0, 5'd11);
        check("rst_write_dropped", {31'd0, obs_write}, 32'd0);
        check("rst_pending_clear", {31'd0, obs_qb}, 32'd0);
        check("rst_tie_alu", {30'd0, obs_ready}, 32'd1);
        idle(3);

        // Randomized run
        for (int c = 0; c < 3000; c++) begin
            if (q0.size() < 4 && $urandom_range(0, 2) != 0) begin
                r.addr = ($urandom_range(0, 9) == 0) ? '0 : rf_addr_t'($urandom);
                r.data = rf_data_t'($urandom);
                q0.push_back(r);
            end
            if (q1.size() < 4 && $urandom_range(0, 2) != 0) begin
                r.addr = ($urandom_range(0, 9) == 0) ? '0 : rf_addr_t'($urandom);
                r.data = rf_data_t'($urandom);
                q1.push_back(r);
            end
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                 rf_addr_t'($urandom), rf_addr_t'($urandom));
        end

        // Drain with a bounded budget
        for (int c = 0; c < 40 && (q0.size() + q1.size()) > 0; c++) idle(1);
        check("drain_timeout", q0.size() + q1.size(), 32'd0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rf_wb_arbiter
